spike_time_decoder: RTL and testbench

- Downstream consumer of temporal-logic gate outputs: converts one edge-coded spike line into a binary arrival time per gamma cycle.
- Counts aclk cycles from the gamma-cycle start and captures the cycle index of the first rising edge on the spike line.
- Emits one result per window over a valid/ready handshake to the binary readout and STDP logic.
- No spike in a window is reported as the "infinity" code.

---
 rtl/spike_time_decoder.sv | 132 +++++++++++++
 tb/tb_spike_time_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_time_decoder.sv
// Edge-coded spike to binary arrival time decoder: one result per gamma window over valid/ready.
// Optional DECODER_INPUT_SYNC_EN adds a 2-flop synchronizer on x with a -2 time compensation.
module spike_time_decoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int TIME_W            = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic              aclk,
  input  logic              grst_n,
  input  logic              gamma_rst,
  input  logic              x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TIME_W-1:0] out_time,
  output logic              out_multi,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURED} state_t;

  localparam logic [TIME_W-1:0] TIME_INF  = TIME_W'(GAMMA_CYCLE_WIDTH);
  localparam logic [TIME_W-1:0] CNT_LAST  = TIME_W'(GAMMA_CYCLE_WIDTH - 1);

  state_t              state_q;
  logic [TIME_W-1:0]   cnt_q;
  logic                x_prev_q;
  logic [TIME_W-1:0]   cap_time_q;
  logic                cap_multi_q;
  logic                out_valid_q;
  logic [TIME_W-1:0]   out_time_q;
  logic                out_multi_q;
  logic                overrun_q;

  logic                x_s;
  logic                rise;
  logic                in_window;
  logic                win_end;
  logic [TIME_W-1:0]   comp_time;
  logic [TIME_W-1:0]   res_time_d;
  logic                res_multi_d;

`ifdef DECODER_INPUT_SYNC_EN
  logic x_meta_q;
  logic x_sync_q;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      x_meta_q <= 1'b0;
      x_sync_q <= 1'b0;
    end else begin
      x_meta_q <= x;
      x_sync_q <= x_meta_q;
    end
  end

  assign x_s = x_sync_q;
  // The synchronizer delays every edge by two cycles; undo that, clamping at 0.
  assign comp_time = (cnt_q >= TIME_W'(2)) ? (cnt_q - TIME_W'(2)) : '0;
`else
  assign x_s       = x;
  assign comp_time = cnt_q;
`endif

  always_comb begin
    rise        = x_s & ~x_prev_q;
    in_window   = (state_q != IDLE);
    win_end     = in_window && ((cnt_q == CNT_LAST) || gamma_rst);
    res_time_d  = TIME_INF;
    res_multi_d = cap_multi_q;
    if (state_q == CAPTURED) begin
      res_time_d  = cap_time_q;
      res_multi_d = cap_multi_q | rise;
    end else if ((state_q == ARMED) && rise) begin
      res_time_d  = comp_time;
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_prev_q    <= 1'b0;
      cap_time_q  <= '0;
      cap_multi_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_time_q  <= '0;
      out_multi_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      x_prev_q <= x_s;

      if (in_window) begin
        cnt_q <= cnt_q + TIME_W'(1);
        if ((state_q == ARMED) && rise) begin
          cap_time_q <= comp_time;
          state_q    <= CAPTURED;
        end
        if ((state_q == CAPTURED) && rise) begin
          cap_multi_q <= 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          state_q <= IDLE;
        end
      end

      // A new window overrides any terminal/early-close transition above.
      if (gamma_rst) begin
        state_q     <= ARMED;
        cnt_q       <= '0;
        x_prev_q    <= 1'b0;
        cap_multi_q <= 1'b0;
      end

      if (win_end) begin
        if (!out_valid_q || out_ready) begin
          out_valid_q <= 1'b1;
          out_time_q  <= res_time_d;
          out_multi_q <= res_multi_d;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_time  = out_time_q;
  assign out_multi = out_multi_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_time_decoder.sv
// Directed self-checking bench for spike_time_decoder (GAMMA_CYCLE_WIDTH=16).
module tb_spike_time_decoder;

  localparam int G = 16;
  localparam int TW = $clog2(G) + 1;

  logic          aclk = 1'b0;
  logic          grst_n = 1'b0;
  logic          gamma_rst = 1'b0;
  logic          x = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [TW-1:0] out_time;
  logic          out_multi;
  logic          overrun;

  int checks = 0;
  int failures = 0;

  spike_time_decoder #(.GAMMA_CYCLE_WIDTH(G)) dut (
    .aclk      (aclk),
    .grst_n    (grst_n),
    .gamma_rst (gamma_rst),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_time  (out_time),
    .out_multi (out_multi),
    .overrun   (overrun)
  );

  always #5 aclk = ~aclk;

  // Pulse gamma_rst for one cycle; returns positioned in window cycle 0.
  task automatic start_gamma();
    gamma_rst = 1'b1;
    @(negedge aclk);
    gamma_rst = 1'b0;
  endtask

  // Drive x for n window cycles from pattern bit 0 upward.
  task automatic drive(input logic [G-1:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      x = pat[i];
      @(negedge aclk);
    end
  endtask

  task automatic expect_result(input string name, input logic v, input logic [TW-1:0] t,
                               input logic m, input logic ov);
    checks++;
    if (out_valid !== v || out_time !== t || out_multi !== m || overrun !== ov) begin
      failures++;
      $display("FAIL %s: got valid=%0b time=%0d multi=%0b overrun=%0b, want valid=%0b time=%0d multi=%0b overrun=%0b",
               name, out_valid, out_time, out_multi, overrun, v, t, m, ov);
    end else begin
      $display("ok   %s: valid=%0b time=%0d multi=%0b overrun=%0b", name, out_valid, out_time, out_multi, overrun);
    end
  endtask

  task automatic expect_valid(input string name, input logic v);
    checks++;
    if (out_valid !== v) begin
      failures++;
      $display("FAIL %s: got valid=%0b, want %0b", name, out_valid, v);
    end else begin
      $display("ok   %s: valid=%0b", name, out_valid);
    end
  endtask

  task automatic test_reset();
    grst_n = 1'b0;
    repeat (2) @(negedge aclk);
    expect_result("reset_state", 1'b0, '0, 1'b0, 1'b0);
    grst_n = 1'b1;
    @(negedge aclk);
    expect_result("after_reset_idle", 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_single_spike();
    out_ready = 1'b1;
    start_gamma();
    drive(16'hFFE0, G);
    expect_result("spike_at_5", 1'b1, TW'(5), 1'b0, 1'b0);
    x = 1'b0;
    @(negedge aclk);
    expect_valid("spike_at_5_consumed", 1'b0);
  endtask

  task automatic test_no_spike();
    start_gamma();
    drive(16'h0000, G);
    expect_result("no_spike_inf", 1'b1, TW'(G), 1'b0, 1'b0);
    @(negedge aclk);
    expect_valid("no_spike_one_cycle", 1'b0);
  endtask

  task automatic test_multi();
    start_gamma();
    drive(16'hFE38, G);
    expect_result("multi_edge", 1'b1, TW'(3), 1'b1, 1'b0);
    x = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_early_close();
    x = 1'b1;
    start_gamma();
    drive(16'hFFFF, G);
    expect_result("held_high_time0", 1'b1, TW'(0), 1'b0, 1'b0);
    x = 1'b0;
    @(negedge aclk);
    start_gamma();
    drive(16'h0000, 7);
    gamma_rst = 1'b1;
    x = 1'b0;
    @(negedge aclk);
    gamma_rst = 1'b0;
    expect_result("early_close_inf", 1'b1, TW'(G), 1'b0, 1'b0);
    drive(16'hFFFC, 1);
    expect_valid("early_close_consumed", 1'b0);
    drive(16'hFFFE, G - 1);
    expect_result("new_window_after_early", 1'b1, TW'(2), 1'b0, 1'b0);
    x = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    start_gamma();
    drive(16'hFFFC, G);
    expect_result("stall_first", 1'b1, TW'(2), 1'b0, 1'b0);
    x = 1'b0;
    start_gamma();
    drive(16'hFFF0, G);
    expect_result("stall_overrun", 1'b1, TW'(2), 1'b0, 1'b1);
    x = 1'b0;
    out_ready = 1'b1;
    @(negedge aclk);
    expect_result("overrun_sticky", 1'b0, TW'(2), 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    bit seen;
    start_gamma();
    drive(16'hFFF0, 8);
    grst_n = 1'b0;
    #1;
    expect_result("async_reset_clear", 1'b0, '0, 1'b0, 1'b0);
    @(negedge aclk);
    grst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (out_valid) seen = 1'b1;
    end
    x = 1'b0;
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL no_result_after_reset: got a result, want none");
    end else begin
      $display("ok   no_result_after_reset");
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    start_gamma();
    drive(16'hFFFE, G);
    expect_result("b2b_first_held", 1'b1, TW'(1), 1'b0, 1'b0);
    x = 1'b0;
    start_gamma();
    drive(16'hFE00, G - 1);
    out_ready = 1'b1;
    drive(16'hFFFF, 1);
    expect_result("b2b_replace", 1'b1, TW'(9), 1'b0, 1'b0);
    x = 1'b0;
    @(negedge aclk);
    expect_result("b2b_consumed", 1'b0, TW'(9), 1'b0, 1'b0);
  endtask

`ifdef DECODER_INPUT_SYNC_EN
  task automatic test_sync();
    out_ready = 1'b1;
    start_gamma();
    drive(16'hFFE0, G);
    expect_result("sync_spike_5", 1'b1, TW'(5), 1'b0, 1'b0);
    x = 1'b0;
    repeat (3) @(negedge aclk);
    start_gamma();
    drive(16'h8000, G);
    expect_result("sync_spike_15_missed", 1'b1, TW'(G), 1'b0, 1'b0);
    x = 1'b0;
    repeat (3) @(negedge aclk);
  endtask
`endif

  initial begin
    @(negedge aclk);
    test_reset();
    test_single_spike();
    test_no_spike();
    test_multi();
    test_early_close();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
`ifdef DECODER_INPUT_SYNC_EN
    test_sync();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
